pulse_scheduler: RTL and testbench

Downstream consumer of the pulse descriptors issued by the core's quantum handler in its execute stage. Buffers descriptors in a small FIFO and returns full/empty status to the core. Plays each pulse in order: it waits the descriptor's delay, then drives channel, amplitude and phase for the descriptor's duration. Operates in the core clock domain.

---
 rtl/pulse_scheduler.sv | 154 +++++++++++++++
 tb/tb_pulse_scheduler.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_scheduler.sv
// Pulse descriptor FIFO plus IDLE/DELAY/PLAY sequencer that plays queued pulses in order.
// Define PULSE_SCHED_OVERFLOW_STICKY_EN to add the sticky overflow_err output.
module pulse_scheduler #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [63:0]              pulse_descriptor,
    input  logic                     pulse_descriptor_valid,
    input  logic                     flush,
    output logic                     pulse_register_full,
    output logic                     pulse_register_empty,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     sched_busy,
    output logic                     pulse_start,
    output logic                     pulse_active,
    output logic [7:0]               pulse_channel,
    output logic [15:0]              pulse_amplitude,
    output logic [15:0]              pulse_phase
`ifdef PULSE_SCHED_OVERFLOW_STICKY_EN
    ,
    output logic                     overflow_err
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [AW:0]      CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]      FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] TICK_ONE = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, DELAY, PLAY} state_t;

    logic [63:0]      mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             push, pop;
    logic [63:0]      head;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             start_q, start_next;

    logic [7:0]       cur_ch;
    logic [15:0]      cur_amp, cur_phase;
    logic [11:0]      cur_dur;

    // A zero duration still plays for one cycle.
    function automatic logic [CNT_W-1:0] sat_duration(input logic [11:0] dur);
        return (dur == 12'd0) ? TICK_ONE : CNT_W'(dur);
    endfunction

    assign pulse_register_full  = (count == FULL_CNT);
    assign pulse_register_empty = (count == '0);
    assign fifo_count           = count;
    assign head                 = mem[rd_ptr];
    assign push                 = pulse_descriptor_valid && !pulse_register_full && !flush;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)      count <= count + CNT_ONE;
            else if (!push && pop) count <= count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= pulse_descriptor;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            start_q <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            start_q <= start_next;
        end
    end

    always_ff @(posedge clk) begin
        if (pop) begin
            cur_ch    <= head[63:56];
            cur_amp   <= head[55:40];
            cur_phase <= head[39:24];
            cur_dur   <= head[23:12];
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        start_next = 1'b0;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop = 1'b1;
                    if (head[11:0] != 12'd0) begin
                        state_next = DELAY;
                        cnt_next   = CNT_W'(head[11:0]);
                    end else begin
                        state_next = PLAY;
                        cnt_next   = sat_duration(head[23:12]);
                        start_next = 1'b1;
                    end
                end
            end
            DELAY: begin
                if (cnt == TICK_ONE) begin
                    state_next = PLAY;
                    cnt_next   = sat_duration(cur_dur);
                    start_next = 1'b1;
                end else begin
                    cnt_next = cnt - TICK_ONE;
                end
            end
            PLAY: begin
                if (cnt == TICK_ONE) state_next = IDLE;
                else                 cnt_next   = cnt - TICK_ONE;
            end
            default: state_next = IDLE;
        endcase
        // Flush aborts the current pulse and suppresses any pop this cycle.
        if (flush) begin
            state_next = IDLE;
            start_next = 1'b0;
            pop        = 1'b0;
        end
    end

    assign pulse_active    = (state == PLAY);
    assign pulse_start     = start_q;
    assign pulse_channel   = pulse_active ? cur_ch    : '0;
    assign pulse_amplitude = pulse_active ? cur_amp   : '0;
    assign pulse_phase     = pulse_active ? cur_phase : '0;
    assign sched_busy      = (state != IDLE) || (count != '0);

`ifdef PULSE_SCHED_OVERFLOW_STICKY_EN
    always_ff @(posedge clk) begin
        if (reset) overflow_err <= 1'b0;
        else if (pulse_descriptor_valid && pulse_register_full) overflow_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_pulse_scheduler.sv
// Scoreboard bench for pulse_scheduler: a cycle-level timing model predicts every output each cycle.
module tb_pulse_scheduler;

    localparam int DEPTH = 8;
    localparam int CNT_W = 12;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [63:0]   pulse_descriptor = '0;
    logic          pulse_descriptor_valid = 1'b0;
    logic          flush = 1'b0;
    logic          pulse_register_full, pulse_register_empty;
    logic [CW-1:0] fifo_count;
    logic          sched_busy, pulse_start, pulse_active;
    logic [7:0]    pulse_channel;
    logic [15:0]   pulse_amplitude, pulse_phase;
`ifdef PULSE_SCHED_OVERFLOW_STICKY_EN
    logic          overflow_err;
`endif

    pulse_scheduler #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .pulse_descriptor       (pulse_descriptor),
        .pulse_descriptor_valid (pulse_descriptor_valid),
        .flush                  (flush),
        .pulse_register_full    (pulse_register_full),
        .pulse_register_empty   (pulse_register_empty),
        .fifo_count             (fifo_count),
        .sched_busy             (sched_busy),
        .pulse_start            (pulse_start),
        .pulse_active           (pulse_active),
        .pulse_channel          (pulse_channel),
        .pulse_amplitude        (pulse_amplitude),
        .pulse_phase            (pulse_phase)
`ifdef PULSE_SCHED_OVERFLOW_STICKY_EN
        ,
        .overflow_err           (overflow_err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  ch;
        logic [15:0] amp;
        logic [15:0] ph;
        int          push;
        int          pop;
        int          start;
        int          last;
    } item_t;

    item_t sb[$];
    item_t cur;
    bit    cur_v   = 1'b0;
    int    free_c  = 0;
    bit    ovf_exp = 1'b0;
    bit    en      = 1'b0;
    int    obs_start = -1;
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Entries pushed before cycle k and not yet popped by the start of cycle k.
    function automatic int model_count(input int k);
        int n;
        n = 0;
        foreach (sb[i]) if (sb[i].push < k && sb[i].pop >= k) n++;
        return n;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] ch, input logic [15:0] amp, input logic [15:0] ph,
                        input logic [11:0] dur, input logic [11:0] dly);
        int    k;
        int    de;
        item_t it;
        k = cyc;
        pulse_descriptor       = {ch, amp, ph, dur, dly};
        pulse_descriptor_valid = 1'b1;
        if (!reset && !flush && model_count(k) < DEPTH) begin
            de       = (dur == 12'd0) ? 1 : int'(dur);
            it.ch    = ch;
            it.amp   = amp;
            it.ph    = ph;
            it.push  = k;
            it.pop   = (k + 1 > free_c) ? k + 1 : free_c;
            it.start = it.pop + 1 + int'(dly);
            it.last  = it.start + de - 1;
            free_c   = it.last + 1;
            sb.push_back(it);
        end
        @(posedge clk);
        #1;
        pulse_descriptor_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        int k;
        int n;
        bit act;
        bit busy;
        if (en) begin
            k = cyc;
            if (sb.size() > 0 && sb[0].start == k) begin
                cur   = sb.pop_front();
                cur_v = 1'b1;
            end
            act  = cur_v && k >= cur.start && k <= cur.last;
            n    = model_count(k);
            busy = (n != 0) || (cur_v && k <= cur.last) || (sb.size() > 0 && sb[0].pop < k);
            if (pulse_start === 1'b1) obs_start = k;
            check("active", pulse_active, act);
            check("start", pulse_start, act && k == cur.start);
            check("channel", pulse_channel, act ? cur.ch : 8'h0);
            check("amplitude", pulse_amplitude, act ? cur.amp : 16'h0);
            check("phase", pulse_phase, act ? cur.ph : 16'h0);
            check("count", fifo_count, n);
            check("full", pulse_register_full, n == DEPTH);
            check("empty", pulse_register_empty, n == 0);
            check("busy", sched_busy, busy);
`ifdef PULSE_SCHED_OVERFLOW_STICKY_EN
            check("overflow", overflow_err, ovf_exp);
`endif
            if (reset || flush) begin
                sb.delete();
                cur_v  = 1'b0;
                free_c = k + 1;
            end
            if (reset) ovf_exp = 1'b0;
            else if (pulse_descriptor_valid && n == DEPTH) ovf_exp = 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        tick(1);
        en = 1'b1;
        check("rst_empty", pulse_register_empty, 1'b1);
        check("rst_full", pulse_register_full, 1'b0);
        check("rst_count", fifo_count, 0);
        check("rst_busy", sched_busy, 1'b0);
        check("rst_active", pulse_active, 1'b0);
        tick(1);
        reset = 1'b0;
        tick(1);

        // Single pulse, no delay
        t0 = cyc;
        push(8'd3, 16'h1234, 16'h0800, 12'd4, 12'd0);
        tick(10);
        check("t1_start_cycle", obs_start, t0 + 2);

        // Delayed pulse
        t0 = cyc;
        push(8'd7, 16'hBEEF, 16'h0101, 12'd2, 12'd5);
        tick(12);
        check("t2_start_cycle", obs_start, t0 + 7);

        // Back-to-back pulses
        t0 = cyc;
        push(8'd1, 16'h1111, 16'h2222, 12'd3, 12'd0);
        push(8'd2, 16'h3333, 16'h4444, 12'd3, 12'd0);
        tick(12);
        check("t3_second_start", obs_start, t0 + 6);

        // Fill behind a long delay, then overflow by one
        push(8'd9, 16'h0909, 16'h9090, 12'd2, 12'd200);
        tick(2);
        for (int i = 0; i < DEPTH + 1; i++)
            push(8'(16 + i), 16'(16'hA000 + i), 16'(16'h0500 + i), 12'(i % 3), 12'd0);
        check("t4_count", fifo_count, DEPTH);
        check("t4_full", pulse_register_full, 1'b1);
`ifdef PULSE_SCHED_OVERFLOW_STICKY_EN
        check("t4_overflow", overflow_err, 1'b1);
`endif
        tick(240);
        check("t4_drained", pulse_register_empty, 1'b1);

        // Flush mid-PLAY with a simultaneous push
        for (int i = 0; i < 4; i++)
            push(8'(40 + i), 16'(16'hC000 + i), 16'(16'h0C00 + i), 12'd20, 12'd0);
        tick(3);
        flush = 1'b1;
        push(8'd99, 16'hDEAD, 16'hFACE, 12'd2, 12'd0);
        flush = 1'b0;
        check("t5_active", pulse_active, 1'b0);
        check("t5_count", fifo_count, 0);
        check("t5_empty", pulse_register_empty, 1'b1);
        check("t5_busy", sched_busy, 1'b0);
        tick(30);

        // Reset mid-DELAY with two entries queued
        push(8'd50, 16'h5050, 16'h0505, 12'd3, 12'd50);
        push(8'd51, 16'h5151, 16'h1515, 12'd3, 12'd0);
        push(8'd52, 16'h5252, 16'h2525, 12'd3, 12'd0);
        tick(3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("t6_count", fifo_count, 0);
        check("t6_empty", pulse_register_empty, 1'b1);
        check("t6_busy", sched_busy, 1'b0);
        check("t6_channel", pulse_channel, 8'h0);
`ifdef PULSE_SCHED_OVERFLOW_STICKY_EN
        check("t6_overflow", overflow_err, 1'b0);
`endif
        tick(60);
        obs_start = -1;
        t0 = cyc;
        push(8'd60, 16'h6060, 16'h0606, 12'd2, 12'd2);
        tick(10);
        check("t6_start_cycle", obs_start, t0 + 4);

        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
